// File: rtl/texture_block_fill.sv
// Cache-fill sequencer for RGB565 texture blocks: one 16-beat SDRAM burst in,
// sixteen RGBA5652 texel writes out to the texture cache line write port.
module texture_block_fill #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LINE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_line,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [LINE_W-1:0] wr_line,
  output logic [3:0]        wr_texel,
  output logic [17:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned BEAT_W  = 16;
  localparam int unsigned BEATS   = 16;
  localparam int unsigned BLOCK_W = BEAT_W * BEATS;

  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [3:0]          beat_q, beat_d;
  logic [3:0]          texel_q, texel_d;
  logic                flush_pend_q, flush_pend_d;
  logic                abort_q, abort_d;
  logic [BLOCK_W-1:0]  block_q;
  logic [BEAT_W-1:0]   pix;
  logic                beat_take;

  assign beat_take = (state_q == RECV) && mem_rvalid;

  // Next-state and latched-context logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    line_d       = line_q;
    beat_d       = beat_q;
    texel_d      = texel_q;
    flush_pend_d = flush_pend_q;
    abort_d      = abort_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          line_d       = req_line;
          beat_d       = 4'd0;
          texel_d      = 4'd0;
          flush_pend_d = 1'b0;
          abort_d      = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (flush)   flush_pend_d = 1'b1;
        if (mem_ack) state_d      = RECV;
      end
      RECV: begin
        // The arbiter cannot cancel a burst, so a flush only takes effect after the last beat
        if (flush) flush_pend_d = 1'b1;
        if (mem_rvalid) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'd15) begin
            if (flush_pend_q || flush) begin
              abort_d = 1'b1;
              state_d = FIN;
            end else begin
              state_d = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (wr_ready) texel_d = texel_q + 4'd1;
        if (flush) begin
          abort_d = 1'b1;
          state_d = FIN;
        end else if (wr_ready && texel_q == 4'd15) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      line_q       <= '0;
      beat_q       <= 4'd0;
      texel_q      <= 4'd0;
      flush_pend_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      texel_q      <= texel_d;
      flush_pend_q <= flush_pend_d;
      abort_q      <= abort_d;
    end
  end

  // Block buffer holds no meaningful value until written, so it carries no reset
  always_ff @(posedge clk) begin
    if (beat_take) block_q[{beat_q, 4'd0} +: BEAT_W] <= mem_rdata;
  end

  assign pix = block_q[{texel_q, 4'd0} +: BEAT_W];

  // Outputs decoded from registered state; wr_data is zero outside WRITE
  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = addr_q;
  assign mem_len   = 5'd16;
  assign wr_valid  = (state_q == WRITE);
  assign wr_line   = line_q;
  assign wr_texel  = texel_q;
  assign wr_data   = (state_q == WRITE) ? {pix[15:11], pix[10:5], pix[4:0], 2'b11} : 18'd0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign aborted   = (state_q == FIN) && abort_q;

endmodule

// File: tb/tb_texture_block_fill.sv
// Directed bench for texture_block_fill: timing, pixel conversion, backpressure,
// slow memory, flush and mid-fill reset.
module tb_texture_block_fill;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LINE_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_line = '0;
  logic              flush = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [4:0]        mem_len;
  logic              mem_ack = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [15:0]       mem_rdata = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [LINE_W-1:0] wr_line;
  logic [3:0]        wr_texel;
  logic [17:0]       wr_data;
  logic              busy;
  logic              done;
  logic              aborted;

  texture_block_fill #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_line(req_line), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_line(wr_line),
    .wr_texel(wr_texel), .wr_data(wr_data), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0]       beat_mem [16];
  logic [3:0]        cap_tex  [32];
  logic [17:0]       cap_dat  [32];
  logic [LINE_W-1:0] cap_lin  [32];
  int   n_wr, done_cyc, req_cyc, stalls, addr_bad, stall_bad;
  logic done_seen, ab_seen, rst_wv, rst_busy, post_done;

  // Drives one fill (cycle 0 = request handshake) and records what the DUT did
  task automatic run_fill(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                          input int ack_delay, input bit gaps, input bit bp, input bit stray,
                          input int flush_beat, input int flush_tex, input int rst_tex);
    int cyc, beat_i, ack_cnt, wcyc;
    bit acked, flushed, stalled;
    logic [3:0]  ptex;
    logic [17:0] pdat;
    n_wr = 0; done_seen = 0; ab_seen = 0; done_cyc = -1; req_cyc = -1;
    stalls = 0; addr_bad = 0; stall_bad = 0; rst_wv = 1; rst_busy = 1; post_done = 0;
    cyc = 0; beat_i = 0; ack_cnt = 0; wcyc = 0; acked = 0; flushed = 0; stalled = 0;
    ptex = '0; pdat = '0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_line = line;
    if (stray) begin mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; end
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_addr = '0; mem_ack = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = '0; flush = 1'b0; wr_ready = 1'b0;
      if (done) begin done_seen = 1; done_cyc = cyc; ab_seen = aborted; end
      if (mem_req) begin
        if (req_cyc < 0) req_cyc = cyc;
        if (mem_addr !== addr || mem_len !== 5'd16) addr_bad++;
      end
      if (wr_valid) begin
        if (stalled && (wr_texel !== ptex || wr_data !== pdat)) stall_bad++;
        if (rst_tex >= 0 && wr_texel == rst_tex[3:0]) begin
          rst_n = 1'b0;
          #1;
          rst_wv = wr_valid; rst_busy = busy;
          @(negedge clk);
          rst_n = 1'b1;
          repeat (4) begin
            @(negedge clk);
            if (done) post_done = 1;
          end
          return;
        end
        wr_ready = bp ? ((wcyc % 4 == 0) || (wcyc % 4 == 3)) : 1'b1;
        wcyc++;
        if (flush_tex >= 0 && !flushed && wr_texel == flush_tex[3:0]) begin
          flush = 1'b1; flushed = 1;
        end
        stalled = !wr_ready; ptex = wr_texel; pdat = wr_data;
        if (!wr_ready) stalls++;
        else if (n_wr < 32) begin
          cap_tex[n_wr] = wr_texel; cap_dat[n_wr] = wr_data; cap_lin[n_wr] = wr_line;
          n_wr++;
        end
      end
      if (acked && beat_i < 16) begin
        if (flush_beat >= 0 && !flushed && beat_i == flush_beat + 1) begin
          flush = 1'b1; flushed = 1;
        end
        if (!gaps || $urandom_range(0, 2) != 0) begin
          mem_rvalid = 1'b1; mem_rdata = beat_mem[beat_i]; beat_i++;
        end
      end else if (mem_req && !acked) begin
        if (stray) begin mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; end
        if (ack_cnt == ack_delay) begin mem_ack = 1'b1; acked = 1; end
        else ack_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_len !== 5'd16) begin bad++; $display("FAIL rst_mem_len got=%0d want=16", mem_len); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b want=0", wr_valid); end
    total++; if (wr_line !== 6'd0) begin bad++; $display("FAIL rst_wr_line got=%0d want=0", wr_line); end
    total++; if (wr_texel !== 4'd0) begin bad++; $display("FAIL rst_wr_texel got=%0d want=0", wr_texel); end
    total++; if (wr_data !== 18'd0) begin bad++; $display("FAIL rst_wr_data got=%h want=0", wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL rst_aborted got=%b want=0", aborted); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'(i);
    run_fill(24'h001000, 6'd5, 0, 0, 0, 0, -1, -1, -1);
    total++; if (req_cyc !== 1) begin bad++; $display("FAIL basic_req_cycle got=%0d want=1", req_cyc); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL basic_mem_addr got=%0d bad cycles want=0", addr_bad); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL basic_writes got=%0d want=16", n_wr); end
    total++; if (done_cyc !== 34) begin bad++; $display("FAIL basic_done_cycle got=%0d want=34", done_cyc); end
    total++; if (ab_seen !== 1'b0) begin bad++; $display("FAIL basic_aborted got=%b want=0", ab_seen); end
    for (int i = 0; i < 16 && i < n_wr; i++) begin
      total++;
      if (cap_tex[i] !== 4'(i) || cap_lin[i] !== 6'd5 || cap_dat[i] !== {16'(i), 2'b11}) begin
        bad++;
        $display("FAIL basic_write%0d got tex=%0d line=%0d data=%h want tex=%0d line=5 data=%h",
                 i, cap_tex[i], cap_lin[i], cap_dat[i], i, {16'(i), 2'b11});
      end
    end
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle_c35 got ready=%b busy=%b want 1 0", req_ready, busy); end
    beat_mem[3] = 16'hF800;
    run_fill(24'h001000, 6'd5, 0, 0, 0, 0, -1, -1, -1);
    total++; if (cap_dat[3] !== 18'h3E003) begin bad++; $display("FAIL basic_texel3 got=%h want=3e003", cap_dat[3]); end
    total++; if (cap_dat[2] !== 18'h0000B) begin bad++; $display("FAIL basic_texel2 got=%h want=0000b", cap_dat[2]); end
  endtask

  task automatic test_bit_mapping();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'h0000;
    beat_mem[0] = 16'hFFFF; beat_mem[1] = 16'h07E0; beat_mem[2] = 16'h001F;
    run_fill(24'hABCDE0, 6'h2A, 0, 0, 0, 0, -1, -1, -1);
    total++; if (cap_dat[0] !== 18'h3FFFF) begin bad++; $display("FAIL map_white got=%h want=3ffff", cap_dat[0]); end
    total++; if (cap_dat[1] !== 18'h01F83) begin bad++; $display("FAIL map_green got=%h want=01f83", cap_dat[1]); end
    total++; if (cap_dat[2] !== 18'h0007F) begin bad++; $display("FAIL map_blue got=%h want=0007f", cap_dat[2]); end
    total++; if (cap_dat[3] !== 18'h00003) begin bad++; $display("FAIL map_black got=%h want=00003", cap_dat[3]); end
    total++; if (cap_lin[0] !== 6'h2A) begin bad++; $display("FAIL map_line got=%h want=2a", cap_lin[0]); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'h1000 + 16'(i);
    run_fill(24'h000400, 6'd9, 0, 0, 1, 0, -1, -1, -1);
    total++; if (n_wr !== 16) begin bad++; $display("FAIL bp_writes got=%0d want=16", n_wr); end
    total++; if (stalls !== 16) begin bad++; $display("FAIL bp_stalls got=%0d want=16", stalls); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d unstable cycles want=0", stall_bad); end
    total++; if (done_cyc !== 50) begin bad++; $display("FAIL bp_done_cycle got=%0d want=50", done_cyc); end
    for (int i = 0; i < 16 && i < n_wr; i++) begin
      total++;
      if (cap_tex[i] !== 4'(i) || cap_dat[i] !== {16'h1000 + 16'(i), 2'b11}) begin
        bad++;
        $display("FAIL bp_write%0d got tex=%0d data=%h want tex=%0d data=%h",
                 i, cap_tex[i], cap_dat[i], i, {16'h1000 + 16'(i), 2'b11});
      end
    end
  endtask

  task automatic test_slow_memory();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'h5A00 ^ (16'(i) * 16'h0111);
    run_fill(24'h7FFFF0, 6'd33, 5, 1, 0, 1, -1, -1, -1);
    total++; if (req_cyc !== 1) begin bad++; $display("FAIL slow_req_cycle got=%0d want=1", req_cyc); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL slow_mem_addr got=%0d bad cycles want=0", addr_bad); end
    total++; if (done_seen !== 1'b1 || ab_seen !== 1'b0) begin bad++; $display("FAIL slow_done got=%b aborted=%b want 1 0", done_seen, ab_seen); end
    total++; if (n_wr !== 16) begin bad++; $display("FAIL slow_writes got=%0d want=16", n_wr); end
    for (int i = 0; i < 16 && i < n_wr; i++) begin
      total++;
      if (cap_dat[i] !== {beat_mem[i], 2'b11}) begin
        bad++;
        $display("FAIL slow_write%0d got=%h want=%h", i, cap_dat[i], {beat_mem[i], 2'b11});
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'h0F0F + 16'(i);
    run_fill(24'h002000, 6'd1, 0, 0, 0, 0, 7, -1, -1);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL flush_recv_writes got=%0d want=0", n_wr); end
    total++; if (done_cyc !== 18 || ab_seen !== 1'b1) begin bad++; $display("FAIL flush_recv_done got cyc=%0d ab=%b want 18 1", done_cyc, ab_seen); end
    run_fill(24'h002000, 6'd1, 0, 0, 0, 0, -1, 4, -1);
    total++; if (n_wr !== 5) begin bad++; $display("FAIL flush_write_writes got=%0d want=5", n_wr); end
    total++; if (done_cyc !== 23 || ab_seen !== 1'b1) begin bad++; $display("FAIL flush_write_done got cyc=%0d ab=%b want 23 1", done_cyc, ab_seen); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done); end
    run_fill(24'h002000, 6'd1, 0, 0, 0, 0, -1, -1, -1);
    total++; if (n_wr !== 16 || ab_seen !== 1'b0) begin bad++; $display("FAIL flush_idle_fill got writes=%0d ab=%b want 16 0", n_wr, ab_seen); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'h3300 + 16'(i);
    run_fill(24'h000040, 6'd7, 0, 0, 0, 0, -1, -1, 9);
    total++; if (rst_wv !== 1'b0 || rst_busy !== 1'b0) begin bad++; $display("FAIL rstmid_outputs got wv=%b busy=%b want 0 0", rst_wv, rst_busy); end
    total++; if (post_done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", post_done); end
    total++; if (n_wr !== 9) begin bad++; $display("FAIL rstmid_writes got=%0d want=9", n_wr); end
    for (int i = 0; i < 16; i++) beat_mem[i] = 16'hA5A0 + 16'(i);
    run_fill(24'h000080, 6'd12, 0, 0, 0, 0, -1, -1, -1);
    total++; if (n_wr !== 16 || done_cyc !== 34) begin bad++; $display("FAIL rstmid_refill got writes=%0d cyc=%0d want 16 34", n_wr, done_cyc); end
    for (int i = 0; i < 16 && i < n_wr; i++) begin
      total++;
      if (cap_tex[i] !== 4'(i) || cap_lin[i] !== 6'd12 || cap_dat[i] !== {16'hA5A0 + 16'(i), 2'b11}) begin
        bad++;
        $display("FAIL rstmid_write%0d got tex=%0d line=%0d data=%h want tex=%0d line=12 data=%h",
                 i, cap_tex[i], cap_lin[i], cap_dat[i], i, {16'hA5A0 + 16'(i), 2'b11});
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_bit_mapping();
    test_backpressure();
    test_slow_memory();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
